// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - single-word memory sequencer: setup, strobe, capture, respond
// Every output is a flop so the memory pins never see a combinational path from the core.
module mem_bus_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic              o_mem_cs,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_accept;

  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_busy;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_mem_rd;
  logic               r_mem_wr;
  logic               r_mem_cs;

  assign w_accept = (r_state == IDLE) && i_req_valid && r_req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = SETUP;
      end
      SETUP: begin
        w_state_nxt = STROBE;
        w_cnt_nxt   = CNT_W'(WAIT_EFF - 1);
      end
      STROBE: begin
        if (r_cnt == '0) w_state_nxt = CAPTURE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      CAPTURE: w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_cs    <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
      r_mem_cs    <= (w_state_nxt == STROBE);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_accept) begin
        r_mem_addr  <= i_req_addr;
        r_mem_wdata <= i_req_wdata;
        r_mem_rd    <= ~i_req_we;
        r_mem_wr    <= i_req_we;
      end
      if (r_state == CAPTURE) begin
        r_mem_rd <= 1'b0;
        r_mem_wr <= 1'b0;
        if (r_mem_rd) r_rsp_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_busy      = r_busy;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_rd    = r_mem_rd;
  assign o_mem_wr    = r_mem_wr;
  assign o_mem_cs    = r_mem_cs;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - directed bench for mem_bus_ctrl with WAIT_CYCLES of 1 and 3
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_vec = 0;
  int          n_err = 0;

  logic        req_valid, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, busy, mem_rd, mem_wr, mem_cs;
  logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem1 [0:65535];

  logic        req_valid2;
  logic        req_ready2, rsp_valid2, busy2, mem_rd2, mem_wr2, mem_cs2;
  logic [15:0] rsp_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
  logic [15:0] mem2 [0:65535];

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_busy(busy),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_rd(mem_rd),
    .o_mem_wr(mem_wr), .o_mem_cs(mem_cs), .i_mem_rdata(mem_rdata)
  );

  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid2), .o_req_ready(req_ready2),
    .i_req_we(1'b0), .i_req_addr(16'h0001), .i_req_wdata(16'h0000),
    .o_rsp_valid(rsp_valid2), .o_rsp_rdata(rsp_rdata2), .o_busy(busy2),
    .o_mem_addr(mem_addr2), .o_mem_wdata(mem_wdata2), .o_mem_rd(mem_rd2),
    .o_mem_wr(mem_wr2), .o_mem_cs(mem_cs2), .i_mem_rdata(mem_rdata2)
  );

  // Level-sensitive memory models: reads are asynchronous, writes commit while cs and wr are high.
  assign mem_rdata  = mem1[mem_addr];
  assign mem_rdata2 = mem2[mem_addr2];
  always @(posedge clk) begin
    if (mem_cs && mem_wr) mem1[mem_addr] <= mem_wdata;
    if (mem_cs2 && mem_wr2) mem2[mem_addr2] <= mem_wdata2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access1(input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd);
    check("ready_pre", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    check("setup_cs", mem_cs, 0);
    check("setup_rd", mem_rd, !we);
    check("setup_wr", mem_wr, we);
    check("setup_addr", mem_addr, a);
    check("setup_busy", busy, 1);
    check("setup_ready", req_ready, 0);
    if (we) check("setup_wdata", mem_wdata, d);
    tick();
    check("strobe_cs", mem_cs, 1);
    check("strobe_rd", mem_rd, !we);
    check("strobe_wr", mem_wr, we);
    tick();
    check("capture_cs", mem_cs, 0);
    check("capture_rd", mem_rd, !we);
    check("capture_wr", mem_wr, we);
    check("capture_rsp", rsp_valid, 0);
    tick();
    check("resp_valid", rsp_valid, 1);
    check("resp_rdata", rsp_rdata, exp_rd);
    check("resp_rd", mem_rd, 0);
    check("resp_wr", mem_wr, 0);
    tick();
    check("idle_rsp", rsp_valid, 0);
    check("idle_ready", req_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_addr_hold", mem_addr, a);
  endtask

  initial begin
    int cs_cnt, first_cs, last_cs, rsp_k, rsp_cnt;
    for (int i = 0; i < 65536; i++) begin
      mem1[i] = 16'h0000;
      mem2[i] = 16'h0000;
    end
    mem1[16'h0000] = 16'h0013; mem1[16'h0001] = 16'h1010; mem1[16'h0201] = 16'h0190;
    mem2[16'h0000] = 16'h0013; mem2[16'h0001] = 16'h1010; mem2[16'h0201] = 16'h0190;
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
    req_valid2 = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", req_ready, 0);
      check("rst_cs", mem_cs, 0);
      check("rst_rsp", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 16'h0000);
      check("rst_busy", busy, 0);
    end
    rst_n = 1'b1; req_valid = 1'b0;
    tick();
    check("rel_ready", req_ready, 1);

    access1(1'b0, 16'h0000, 16'h0000, 16'h0013);
    access1(1'b1, 16'h0101, 16'hBEEF, 16'h0013);
    check("mem_0101", mem1[16'h0101], 16'hBEEF);
    access1(1'b0, 16'h0101, 16'h0000, 16'hBEEF);

    // Request held high through a read: the second one waits for the IDLE cycle.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0000;
    tick();
    req_addr = 16'h0201;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("b2b_addr_hold", mem_addr, 16'h0000);
      check("b2b_ready", req_ready, (k == 4));
      if (k == 3) begin
        check("b2b_rsp1", rsp_valid, 1);
        check("b2b_rdata1", rsp_rdata, 16'h0013);
      end
    end
    tick();
    req_valid = 1'b0;
    check("b2b_accept_addr", mem_addr, 16'h0201);
    check("b2b_accept_busy", busy, 1);
    tick(); tick(); tick();
    check("b2b_rsp2", rsp_valid, 1);
    check("b2b_rdata2", rsp_rdata, 16'h0190);
    tick();
    check("b2b_idle", req_ready, 1);

    // WAIT_CYCLES=3 instance.
    check("w3_ready", req_ready2, 1);
    req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
    cs_cnt = 0; first_cs = -1; last_cs = -1; rsp_k = -1; rsp_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (mem_cs2) begin
        cs_cnt++;
        if (first_cs < 0) first_cs = k;
        last_cs = k;
      end
      if (rsp_valid2) begin
        rsp_cnt++;
        if (rsp_k < 0) rsp_k = k;
        check("w3_rdata", rsp_rdata2, 16'h1010);
      end
      tick();
    end
    check("w3_cs_count", cs_cnt, 3);
    check("w3_cs_span", last_cs - first_cs, 2);
    check("w3_rsp_edge", rsp_k, 5);
    check("w3_rsp_count", rsp_cnt, 1);

    // Reset in the middle of a strobe.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0000;
    tick();
    req_valid = 1'b0;
    tick();
    check("mid_strobe_cs", mem_cs, 1);
    rst_n = 1'b0;
    tick();
    check("mid_cs", mem_cs, 0);
    check("mid_rd", mem_rd, 0);
    check("mid_busy", busy, 0);
    check("mid_rsp", rsp_valid, 0);
    check("mid_rdata", rsp_rdata, 16'h0000);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_no_rsp", rsp_valid, 0);
    end
    access1(1'b0, 16'h0000, 16'h0000, 16'h0013);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
